bullet_controller: RTL and testbench

Per-tank bullet engine that sits directly upstream of the collision checker. It owns one bullet per tank and drives that bullet's position, travel direction and launch-point latch (saveX/saveY) into the collision checker. It consumes the checker's wall-hit and tank-alive verdicts to retire the bullet and to enforce a refire cooldown. The top level instantiates it twice, once per tank, and cross-wires `target_alive` to the opposing tank's alive flag.

---
 rtl/bullet_controller.sv | 202 ++++++++++++++++++++
 tb/tb_bullet_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_controller.sv
// -----------------------------------------------------------------------------
// bullet_controller
//
// Owns the single bullet of one tank. Launches it from the tank centre on a
// rising edge of the fire button, steps it one STEP_B per frame tick along the
// launch direction, and retires it on a target kill, a wall hit or a screen
// exit. A retired bullet is followed by a COOLDOWN_FRAMES-tick refire cooldown.
//
// Ports
//   Clk          : system clock
//   Reset        : synchronous, active-high reset
//   frame_tick   : one-Clk pulse per video frame
//   fire         : fire button level (acted on at its rising edge)
//   X_Tank       : owning tank top-left X
//   Y_Tank       : owning tank top-left Y
//   tank_dir     : owning tank motion (0 still, 1 up, 2 right, 3 left, 4 down)
//   hit          : checker verdict for this bullet (2'b00 = wall hit)
//   target_alive : checker verdict for the opposing tank (0 = struck)
//   X_Bullet     : bullet top-left X (0 when no bullet)
//   Y_Bullet     : bullet top-left Y (0 when no bullet)
//   bullet_dir   : bullet direction, 0 = no bullet
//   saveX        : tank X latched at launch
//   saveY        : tank Y latched at launch
//   kill         : one-Clk pulse when this bullet destroys the target
//   ready        : high while a new shot may be fired
// -----------------------------------------------------------------------------
module bullet_controller #(
  parameter logic [9:0] STEP_B          = 10'd5,
  parameter logic [9:0] BULLET_SIZE     = 10'd8,
  parameter logic [9:0] TANK_SIZE       = 10'd32,
  parameter logic [9:0] SCREEN_W        = 10'd640,
  parameter logic [9:0] SCREEN_H        = 10'd480,
  parameter logic [4:0] COOLDOWN_FRAMES = 5'd16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] X_Tank,
  input  logic [9:0] Y_Tank,
  input  logic [2:0] tank_dir,
  input  logic [1:0] hit,
  input  logic       target_alive,
  output logic [9:0] X_Bullet,
  output logic [9:0] Y_Bullet,
  output logic [2:0] bullet_dir,
  output logic [9:0] saveX,
  output logic [9:0] saveY,
  output logic       kill,
  output logic       ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  // Offset that centres the bullet square inside the tank square.
  localparam logic [9:0] SPAWN_OFS = (TANK_SIZE - BULLET_SIZE) >> 1;

  // Far-edge limits in 11 bits so the sum cannot overflow.
  localparam logic [10:0] FAR_REACH = {1'b0, BULLET_SIZE} + {1'b0, STEP_B};

  state_t     state_q;
  logic [9:0] x_bullet_q;
  logic [9:0] y_bullet_q;
  logic [2:0] bullet_dir_q;
  logic [9:0] save_x_q;
  logic [9:0] save_y_q;
  logic       kill_q;
  logic       ready_q;
  logic [4:0] cd_cnt_q;
  logic       fire_q;
  logic [2:0] face_q;
  // Set when fire is high during reset; blocks launches until fire is released.
  logic       fire_hold_q;

  logic       fire_rise_d;
  logic       exit_d;
  logic       retire_d;
  logic [9:0] x_step_d;
  logic [9:0] y_step_d;

  assign fire_rise_d = fire & ~fire_q & ~fire_hold_q;

  // Screen-exit test for the next step; evaluated before any subtraction so
  // the position never wraps below zero.
  always_comb begin
    exit_d = 1'b0;
    case (bullet_dir_q)
      DIR_UP:    exit_d = (y_bullet_q < STEP_B);
      DIR_LEFT:  exit_d = (x_bullet_q < STEP_B);
      DIR_RIGHT: exit_d = ({1'b0, x_bullet_q} + FAR_REACH) > {1'b0, SCREEN_W};
      DIR_DOWN:  exit_d = ({1'b0, y_bullet_q} + FAR_REACH) > {1'b0, SCREEN_H};
      default:   exit_d = 1'b0;
    endcase
  end

  always_comb begin
    x_step_d = x_bullet_q;
    y_step_d = y_bullet_q;
    case (bullet_dir_q)
      DIR_UP:    y_step_d = y_bullet_q - STEP_B;
      DIR_LEFT:  x_step_d = x_bullet_q - STEP_B;
      DIR_RIGHT: x_step_d = x_bullet_q + STEP_B;
      DIR_DOWN:  y_step_d = y_bullet_q + STEP_B;
      default: begin
        x_step_d = x_bullet_q;
        y_step_d = y_bullet_q;
      end
    endcase
  end

  // Kill outranks wall hit, which outranks screen exit; all three retire.
  assign retire_d = frame_tick & (~target_alive | (hit == 2'b00) | exit_d);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      x_bullet_q   <= 10'd0;
      y_bullet_q   <= 10'd0;
      bullet_dir_q <= 3'd0;
      save_x_q     <= 10'd0;
      save_y_q     <= 10'd0;
      kill_q       <= 1'b0;
      ready_q      <= 1'b1;
      cd_cnt_q     <= 5'd0;
      fire_q       <= 1'b0;
      face_q       <= DIR_UP;
      fire_hold_q  <= fire;
    end else begin
      fire_q <= fire;
      if (!fire) begin
        fire_hold_q <= 1'b0;
      end
      // Only legal directions are remembered, so a bullet always moves.
      if (tank_dir >= DIR_UP && tank_dir <= DIR_DOWN) begin
        face_q <= tank_dir;
      end
      kill_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (fire_rise_d) begin
            state_q      <= S_FLYING;
            ready_q      <= 1'b0;
            bullet_dir_q <= face_q;
            save_x_q     <= X_Tank;
            save_y_q     <= Y_Tank;
            x_bullet_q   <= X_Tank + SPAWN_OFS;
            y_bullet_q   <= Y_Tank + SPAWN_OFS;
          end
        end

        S_FLYING: begin
          if (retire_d) begin
            state_q      <= S_COOLDOWN;
            kill_q       <= ~target_alive;
            bullet_dir_q <= 3'd0;
            x_bullet_q   <= 10'd0;
            y_bullet_q   <= 10'd0;
            cd_cnt_q     <= COOLDOWN_FRAMES - 5'd1;
          end else if (frame_tick) begin
            x_bullet_q <= x_step_d;
            y_bullet_q <= y_step_d;
          end
        end

        S_COOLDOWN: begin
          if (frame_tick) begin
            if (cd_cnt_q == 5'd0) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end else begin
              cd_cnt_q <= cd_cnt_q - 5'd1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign X_Bullet   = x_bullet_q;
  assign Y_Bullet   = y_bullet_q;
  assign bullet_dir = bullet_dir_q;
  assign saveX      = save_x_q;
  assign saveY      = save_y_q;
  assign kill       = kill_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_bullet_controller.sv
// -----------------------------------------------------------------------------
// tb_bullet_controller
//
// Directed bench for bullet_controller: launch, flight, kill/wall/screen-exit
// retirement, cooldown length, dropped fire edges and reset with fire held.
// -----------------------------------------------------------------------------
module tb_bullet_controller;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic       fire;
  logic [9:0] X_Tank;
  logic [9:0] Y_Tank;
  logic [2:0] tank_dir;
  logic [1:0] hit;
  logic       target_alive;
  logic [9:0] X_Bullet;
  logic [9:0] Y_Bullet;
  logic [2:0] bullet_dir;
  logic [9:0] saveX;
  logic [9:0] saveY;
  logic       kill;
  logic       ready;

  int checks_cnt;
  int errors_cnt;

  bullet_controller dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .fire         (fire),
    .X_Tank       (X_Tank),
    .Y_Tank       (Y_Tank),
    .tank_dir     (tank_dir),
    .hit          (hit),
    .target_alive (target_alive),
    .X_Bullet     (X_Bullet),
    .Y_Bullet     (Y_Bullet),
    .bullet_dir   (bullet_dir),
    .saveX        (saveX),
    .saveY        (saveY),
    .kill         (kill),
    .ready        (ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press();
    fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  initial begin
    checks_cnt   = 0;
    errors_cnt   = 0;
    Reset        = 1'b1;
    frame_tick   = 1'b0;
    fire         = 1'b0;
    X_Tank       = 10'd100;
    Y_Tank       = 10'd200;
    tank_dir     = 3'd0;
    hit          = 2'b01;
    target_alive = 1'b1;
    repeat (3) step();
    Reset = 1'b0;

    // Reset state
    check("rst_dir",   32'(bullet_dir), 0);
    check("rst_x",     32'(X_Bullet),   0);
    check("rst_y",     32'(Y_Bullet),   0);
    check("rst_savex", 32'(saveX),      0);
    check("rst_savey", 32'(saveY),      0);
    check("rst_kill",  32'(kill),       0);
    check("rst_ready", 32'(ready),      1);
    step();

    // Launch from a still tank uses the reset facing (up)
    press();
    check("launch_dir",   32'(bullet_dir), 1);
    check("launch_x",     32'(X_Bullet),   112);
    check("launch_y",     32'(Y_Bullet),   212);
    check("launch_savex", 32'(saveX),      100);
    check("launch_savey", 32'(saveY),      200);
    check("launch_ready", 32'(ready),      0);

    // Wall hit retires without a kill; cooldown is 16 ticks after the retire tick
    hit = 2'b00;
    frame();
    hit = 2'b01;
    check("wall_dir",  32'(bullet_dir), 0);
    check("wall_kill", 32'(kill),       0);
    check("wall_y",    32'(Y_Bullet),   0);
    check("wall_savey_hold", 32'(saveY), 200);
    frames(15);
    check("cd15_ready", 32'(ready), 0);
    frame();
    check("cd16_ready", 32'(ready), 1);

    // Facing right, three ticks of flight
    tank_dir = 3'd2;
    step();
    tank_dir = 3'd0;
    press();
    check("right_dir", 32'(bullet_dir), 2);
    check("right_x0",  32'(X_Bullet),   112);
    tank_dir = 3'd3;  // steering mid-flight must not affect the bullet
    frames(3);
    step();           // non-tick cycle holds position
    check("right_x3", 32'(X_Bullet),   127);
    check("right_y3", 32'(Y_Bullet),   212);
    check("right_d3", 32'(bullet_dir), 2);

    // Kill and wall hit on the same tick: kill wins, one-cycle pulse
    hit          = 2'b00;
    target_alive = 1'b0;
    frame();
    hit          = 2'b01;
    target_alive = 1'b1;
    check("kill_pulse", 32'(kill),       1);
    check("kill_dir",   32'(bullet_dir), 0);
    check("kill_x",     32'(X_Bullet),   0);
    step();
    check("kill_clear", 32'(kill), 0);
    frames(15);
    check("kcd15_ready", 32'(ready), 0);
    frame();
    check("kcd16_ready", 32'(ready), 1);

    // Upward bullet near the top: Y=14 -> 9 -> 4, then exit without wrap
    tank_dir = 3'd1;
    X_Tank   = 10'd300;
    Y_Tank   = 10'd2;
    step();
    press();
    check("up_y0", 32'(Y_Bullet), 14);
    frames(2);
    check("up_y2", 32'(Y_Bullet), 4);
    frame();
    check("up_exit_dir", 32'(bullet_dir), 0);
    check("up_exit_y",   32'(Y_Bullet),   0);
    // Fire edge during cooldown is dropped
    press();
    step();
    check("cd_fire_dir",   32'(bullet_dir), 0);
    check("cd_fire_ready", 32'(ready),      0);
    frames(15);
    check("ucd15_ready", 32'(ready), 0);
    // Fire rising on the tick that enters IDLE is ignored
    fire = 1'b1;
    frame();
    check("enter_idle_ready", 32'(ready),      1);
    check("enter_idle_dir",   32'(bullet_dir), 0);
    step();
    check("held_no_launch", 32'(bullet_dir), 0);
    fire = 1'b0;
    step();
    press();
    check("relaunch_dir", 32'(bullet_dir), 1);
    check("relaunch_x",   32'(X_Bullet),   312);

    // Reset mid-flight with fire held high
    fire  = 1'b1;
    Reset = 1'b1;
    step();
    check("midrst_dir",   32'(bullet_dir), 0);
    check("midrst_x",     32'(X_Bullet),   0);
    check("midrst_savex", 32'(saveX),      0);
    check("midrst_ready", 32'(ready),      1);
    Reset = 1'b0;
    repeat (3) step();
    check("held_after_rst_dir",   32'(bullet_dir), 0);
    check("held_after_rst_ready", 32'(ready),      1);
    fire = 1'b0;
    step();
    press();
    check("post_rst_launch_dir", 32'(bullet_dir), 1);
    check("post_rst_launch_y",   32'(Y_Bullet),   14);

    // Right edge: X=627 may still step to 632, then 632 exits
    Reset = 1'b1;
    step();
    Reset    = 1'b0;
    tank_dir = 3'd2;
    X_Tank   = 10'd615;
    Y_Tank   = 10'd100;
    step();
    press();
    check("edge_x0", 32'(X_Bullet), 627);
    frame();
    check("edge_x1",   32'(X_Bullet),   632);
    check("edge_dir1", 32'(bullet_dir), 2);
    frame();
    check("edge_exit_dir",  32'(bullet_dir), 0);
    check("edge_exit_kill", 32'(kill),       0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
